// File: rtl/regfile_pkg.sv
// Purpose: shared register-file constants and types for the writeback path.
// Contents: XLEN/AW/NREGS sizes, address and data word types, the r0 address.
package regfile_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned AW    = 5;
  localparam int unsigned NREGS = 32;

  typedef logic [AW-1:0]   reg_addr_t;
  typedef logic [XLEN-1:0] xword_t;

  localparam reg_addr_t ZERO_REG = 5'd0;

endpackage

// File: rtl/regfile_wr_arbiter_rr_picker.sv
// Purpose: combinational round-robin picker. Finds the first set request
// at or above ptr, wrapping past N-1 back to 0.
// Ports:
//   req  [N-1:0]  request vector
//   ptr  [IW-1:0] index the search starts from (must be < N)
//   gnt  [N-1:0]  one-hot grant
//   gidx [IW-1:0] index of the granted request
//   any           at least one request is set
module rr_picker #(
  parameter  int unsigned N  = 3,
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gidx,
  output logic          any
);

  logic [IW:0]   w_sum;
  logic [IW-1:0] w_idx;

  // Walk offsets 0..N-1 from ptr; the first hit wins.
  always_comb begin
    gnt   = '0;
    gidx  = '0;
    any   = 1'b0;
    w_sum = '0;
    w_idx = '0;
    for (int unsigned k = 0; k < N; k++) begin
      w_sum = {1'b0, ptr} + (IW+1)'(k);
      if (w_sum >= (IW+1)'(N)) begin
        w_sum = w_sum - (IW+1)'(N);
      end
      w_idx = w_sum[IW-1:0];
      if (!any && req[w_idx]) begin
        any        = 1'b1;
        gnt[w_idx] = 1'b1;
        gidx       = w_idx;
      end
    end
  end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Purpose: round-robin arbiter sharing the single register-file write port
// between NREQ writeback requesters. The winner's address/data are registered
// onto the port one cycle after acceptance; writes to r0 handshake normally
// but never raise wr_en.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   req_valid [NREQ]    per-requester write request
//   req_addr  [NREQ*AW] destination register, requester i at [i*AW +: AW]
//   req_data  [NREQ*XLEN] write data, requester i at [i*XLEN +: XLEN]
//   req_ready [NREQ]    one-hot acceptance (combinational)
//   port_stall          write port unavailable this cycle
//   wr_en, wr_sel, wr_data  registered write port (wr_sel feeds the decoder)
//   grant_id            registered index of the last granted requester
//   wr_count            saturating count of writes issued with wr_en=1
module regfile_wr_arbiter
  import regfile_pkg::*;
#(
  parameter  int unsigned NREQ = 3,
  parameter  int unsigned XLEN = regfile_pkg::XLEN,
  parameter  int unsigned AW   = regfile_pkg::AW,
  localparam int unsigned GW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*AW-1:0]   req_addr,
  input  logic [NREQ*XLEN-1:0] req_data,
  output logic [NREQ-1:0]      req_ready,
  input  logic                 port_stall,
  output logic                 wr_en,
  output logic [AW-1:0]        wr_sel,
  output logic [XLEN-1:0]      wr_data,
  output logic [GW-1:0]        grant_id,
  output logic [15:0]          wr_count
);

  localparam int unsigned CW   = 16;
  localparam logic [CW-1:0] CMAX = '1;

  logic [GW-1:0]   r_rr_ptr;
  logic            r_wr_en;
  logic [AW-1:0]   r_wr_sel;
  logic [XLEN-1:0] r_wr_data;
  logic [GW-1:0]   r_grant_id;
  logic [CW-1:0]   r_wr_count;

  logic [NREQ-1:0] w_gnt;
  logic [GW-1:0]   w_gidx;
  logic            w_any;
  logic            w_open;
  logic            w_xfer;
  logic            w_nz;
  logic [AW-1:0]   w_addr;
  logic [XLEN-1:0] w_data;
  logic [GW-1:0]   w_ptr_nxt;

  rr_picker #(.N(NREQ)) u_picker (
    .req  (req_valid),
    .ptr  (r_rr_ptr),
    .gnt  (w_gnt),
    .gidx (w_gidx),
    .any  (w_any)
  );

  // Reset and stall both close the port to every requester.
  assign w_open    = !rst && !port_stall;
  assign req_ready = w_open ? w_gnt : '0;
  assign w_xfer    = w_open && w_any;

  // Select the winner's address and data.
  always_comb begin
    w_addr = '0;
    w_data = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (w_gidx == GW'(i)) begin
        w_addr = req_addr[i*AW +: AW];
        w_data = req_data[i*XLEN +: XLEN];
      end
    end
  end

  assign w_nz      = (w_addr != AW'(ZERO_REG));
  assign w_ptr_nxt = (w_gidx == GW'(NREQ-1)) ? '0 : w_gidx + GW'(1);

  // Write-port, pointer and counter registers; a stall freezes all of them.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr   <= '0;
      r_wr_en    <= 1'b0;
      r_wr_sel   <= '0;
      r_wr_data  <= '0;
      r_grant_id <= '0;
      r_wr_count <= '0;
    end else if (!port_stall) begin
      if (w_xfer) begin
        r_wr_sel   <= w_addr;
        r_wr_data  <= w_data;
        r_grant_id <= w_gidx;
        r_wr_en    <= w_nz;
        r_rr_ptr   <= w_ptr_nxt;
        if (w_nz && (r_wr_count != CMAX)) begin
          r_wr_count <= r_wr_count + CW'(1);
        end
      end else begin
        r_wr_en <= 1'b0;
      end
    end
  end

  assign wr_en    = r_wr_en;
  assign wr_sel   = r_wr_sel;
  assign wr_data  = r_wr_data;
  assign grant_id = r_grant_id;
  assign wr_count = r_wr_count;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Purpose: directed bench for regfile_wr_arbiter (NREQ=3). The driver checks
// req_ready against hand-written vectors and queues the write each accepted
// non-r0 request must produce; a monitor pops and compares on every new write.
module tb_regfile_wr_arbiter;

  typedef struct packed {
    logic [4:0]  sel;
    logic [31:0] data;
    logic [1:0]  gid;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        port_stall;
  logic [2:0]  req_valid;
  logic [4:0]  a [3];
  logic [31:0] d [3];
  logic [14:0] req_addr;
  logic [95:0] req_data;
  logic [2:0]  req_ready;
  logic        wr_en;
  logic [4:0]  wr_sel;
  logic [31:0] wr_data;
  logic [1:0]  grant_id;
  logic [15:0] wr_count;

  exp_t q[$];
  exp_t e;
  logic st_s, rst_s;
  int   n_checks = 0;
  int   n_pass   = 0;

  assign req_addr = {a[2], a[1], a[0]};
  assign req_data = {d[2], d[1], d[0]};

  always #5 clk = ~clk;

  regfile_wr_arbiter #(.NREQ(3), .XLEN(32), .AW(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_addr   (req_addr),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .port_stall (port_stall),
    .wr_en      (wr_en),
    .wr_sel     (wr_sel),
    .wr_data    (wr_data),
    .grant_id   (grant_id),
    .wr_count   (wr_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // One cycle: apply inputs at negedge, check ready, queue the expected write.
  task automatic cyc(input logic r, input logic st, input logic [2:0] v, input logic [2:0] exp_rdy);
    int g;
    @(negedge clk);
    rst = r;
    port_stall = st;
    req_valid = v;
    #1;
    check("req_ready", 32'(req_ready), 32'(exp_rdy));
    g = -1;
    for (int i = 0; i < 3; i++) if (exp_rdy[i]) g = i;
    if (g >= 0 && a[g] != 5'd0) q.push_back('{sel: a[g], data: d[g], gid: 2'(g)});
    @(posedge clk);
    #2;
  endtask

  task automatic outs(input logic en, input logic [4:0] sel, input logic [31:0] data,
                      input logic [1:0] gid, input logic [15:0] cnt);
    check("wr_en", 32'(wr_en), 32'(en));
    check("wr_sel", 32'(wr_sel), 32'(sel));
    check("wr_data", wr_data, data);
    check("grant_id", 32'(grant_id), 32'(gid));
    check("wr_count", 32'(wr_count), 32'(cnt));
  endtask

  // Monitor: a new write is wr_en=1 after a non-stalled, non-reset edge.
  initial begin
    forever begin
      @(posedge clk);
      st_s  = port_stall;
      rst_s = rst;
      #1;
      if (wr_en && !st_s && !rst_s) begin
        if (q.size() == 0) begin
          check("unexpected_write", 32'(wr_sel), 32'hFFFF_FFFF);
        end else begin
          e = q.pop_front();
          check("mon_wr_sel", 32'(wr_sel), 32'(e.sel));
          check("mon_wr_data", wr_data, e.data);
          check("mon_grant_id", 32'(grant_id), 32'(e.gid));
        end
      end
    end
  end

  initial begin
    rst = 1'b1; port_stall = 1'b0; req_valid = 3'b111;
    a[0] = 5'd5; a[1] = 5'd6; a[2] = 5'd7;
    d[0] = 32'hA; d[1] = 32'hB; d[2] = 32'hC;

    // Reset held two cycles with all requests valid.
    cyc(1'b1, 1'b0, 3'b111, 3'b000);
    outs(1'b0, 5'd0, 32'h0, 2'd0, 16'd0);
    cyc(1'b1, 1'b0, 3'b111, 3'b000);
    outs(1'b0, 5'd0, 32'h0, 2'd0, 16'd0);

    // Round-robin with all valid: 0,1,2,0,1,2.
    cyc(1'b0, 1'b0, 3'b111, 3'b001);
    outs(1'b1, 5'd5, 32'hA, 2'd0, 16'd1);
    cyc(1'b0, 1'b0, 3'b111, 3'b010);
    cyc(1'b0, 1'b0, 3'b111, 3'b100);
    cyc(1'b0, 1'b0, 3'b111, 3'b001);
    cyc(1'b0, 1'b0, 3'b111, 3'b010);
    cyc(1'b0, 1'b0, 3'b111, 3'b100);
    outs(1'b1, 5'd7, 32'hC, 2'd2, 16'd6);

    // r0 write from requester 1: handshakes, no wr_en, no count.
    a[1] = 5'd0; d[1] = 32'hDEAD;
    cyc(1'b0, 1'b0, 3'b010, 3'b010);
    outs(1'b0, 5'd0, 32'hDEAD, 2'd1, 16'd6);
    // Search now starts at 2.
    a[1] = 5'd6; d[1] = 32'hB;
    cyc(1'b0, 1'b0, 3'b111, 3'b100);
    outs(1'b1, 5'd7, 32'hC, 2'd2, 16'd7);

    // Stall three cycles with requester 2 pending: everything holds.
    a[2] = 5'd9; d[2] = 32'h99;
    cyc(1'b0, 1'b1, 3'b100, 3'b000);
    outs(1'b1, 5'd7, 32'hC, 2'd2, 16'd7);
    cyc(1'b0, 1'b1, 3'b100, 3'b000);
    cyc(1'b0, 1'b1, 3'b100, 3'b000);
    outs(1'b1, 5'd7, 32'hC, 2'd2, 16'd7);
    cyc(1'b0, 1'b0, 3'b100, 3'b100);
    outs(1'b1, 5'd9, 32'h99, 2'd2, 16'd8);

    // Mid-operation reset: requester 0 wins first after release.
    a[1] = 5'd3; d[1] = 32'h33;
    cyc(1'b0, 1'b0, 3'b010, 3'b010);
    outs(1'b1, 5'd3, 32'h33, 2'd1, 16'd9);
    cyc(1'b1, 1'b0, 3'b011, 3'b000);
    outs(1'b0, 5'd0, 32'h0, 2'd0, 16'd0);
    cyc(1'b0, 1'b0, 3'b011, 3'b001);
    outs(1'b1, 5'd5, 32'hA, 2'd0, 16'd1);
    cyc(1'b0, 1'b0, 3'b010, 3'b010);
    outs(1'b1, 5'd3, 32'h33, 2'd1, 16'd2);
    cyc(1'b0, 1'b0, 3'b000, 3'b000);
    outs(1'b0, 5'd3, 32'h33, 2'd1, 16'd2);

    // Counter saturation.
    cyc(1'b1, 1'b0, 3'b000, 3'b000);
    outs(1'b0, 5'd0, 32'h0, 2'd0, 16'd0);
    a[0] = 5'd1; d[0] = 32'h5A5A;
    for (int i = 0; i < 65534; i++) cyc(1'b0, 1'b0, 3'b001, 3'b001);
    check("wr_count_fffe", 32'(wr_count), 32'hFFFE);
    cyc(1'b0, 1'b0, 3'b001, 3'b001);
    check("wr_count_ffff", 32'(wr_count), 32'hFFFF);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 3'b001, 3'b001);
    outs(1'b1, 5'd1, 32'h5A5A, 2'd0, 16'hFFFF);

    cyc(1'b0, 1'b0, 3'b000, 3'b000);
    check("queue_empty", 32'(q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
